// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   state_t  - arbiter FSM states (IDLE, GRANT)
//   DEF_*    - default configuration constants
//   onehot8  - index to one-hot helper (up to 8 requesters)
package rr_mux_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MAX_N        = 8;
  localparam int DEF_N        = 8;
  localparam int DEF_SEL_W    = 3;
  localparam int DEF_HOLD_W   = 4;
  localparam int DEF_MAX_HOLD = 4;

  // Callers slice the low N bits for narrower configurations.
  function automatic logic [MAX_N-1:0] onehot8(input logic [2:0] idx);
    logic [MAX_N-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mux8to1.sv
// Plain 8:1 one-bit multiplexer.
// Ports:
//   d   [7:0] data inputs
//   sel [2:0] select
//   y         d[sel]
module mux8to1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = d[sel];

endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational cyclic priority encoder (module rr_pick).
// Finds the first set bit of req starting at index start and wrapping
// from N-1 back to 0.
// Ports:
//   req   [N-1:0]     candidate requests (already masked by the caller)
//   start [SEL_W-1:0] index with highest priority
//   found             any bit of req set
//   idx   [SEL_W-1:0] winning index (0 when nothing found)
module rr_pick #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan farthest-first so the nearest set bit (lowest offset) is the
  // last assignment and wins. N is a power of two, so the SEL_W-bit
  // addition wraps modulo N on its own.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = start + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for a shared 8:1 one-bit mux.
// One requester is granted at a time; its tenure ends when it drops its
// request, or after MAX_HOLD cycles if someone else is waiting. The mux
// output of the granted input is registered onto y.
// Optional feature: define RR_MUX_ARBITER_LOCK_EN to add a lock input that
// suppresses the hold-limit release while the granted requester holds it.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req  [N-1:0] level-sensitive requests
//   in   [N-1:0] mux data inputs
//   lock         (RR_MUX_ARBITER_LOCK_EN only) keep current grant past limit
//   gnt  [N-1:0] registered one-hot grant
//   sel  [SEL_W-1:0] registered mux select (index of granted requester)
//   busy         a grant is active
//   y            registered in[sel] while busy, else 0
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int HOLD_W   = DEF_HOLD_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     in,
`ifdef RR_MUX_ARBITER_LOCK_EN
  input  logic             lock,
`endif
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             y
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              y_q, y_d;

  logic [MAX_N-1:0]  cur_full, win_full;
  logic [N-1:0]      cur_mask, win_mask;
  logic [N-1:0]      pick_req;
  logic [SEL_W-1:0]  pick_start;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;
  logic              others_req;
  logic              release_drop, release_limit, release_any;
  logic [7:0]        mux_d;
  logic [2:0]        mux_sel;
  logic              mux_y;

  always_comb begin
    cur_full = onehot8(3'(sel_q));
    win_full = onehot8(3'(pick_idx));
    cur_mask = cur_full[N-1:0];
    win_mask = win_full[N-1:0];
  end

  // In IDLE the search runs over the raw requests from ptr. While granted
  // the same encoder looks for a successor: current holder masked out,
  // searching from the slot after it.
  always_comb begin
    pick_req   = req;
    pick_start = ptr_q;
    if (state_q == GRANT) begin
      pick_req   = req & ~cur_mask;
      pick_start = sel_q + 1'b1;
    end
  end

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    others_req    = |(req & ~cur_mask);
    release_drop  = ~req[sel_q];
    release_limit = (hold_cnt_q == HOLD_MAX) && others_req;
`ifdef RR_MUX_ARBITER_LOCK_EN
    if (lock && req[sel_q]) begin
      release_limit = 1'b0;
    end
`endif
    // Drop and limit together are a single release.
    release_any   = release_drop || release_limit;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    case (state_q)
      IDLE: begin
        // With no request, sel deliberately keeps its last value.
        if (pick_found) begin
          state_d    = GRANT;
          gnt_d      = win_mask;
          sel_d      = pick_idx;
          hold_cnt_d = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (release_any) begin
          ptr_d = sel_q + 1'b1;
          if (pick_found) begin
            // Direct hand-over, no idle bubble.
            gnt_d      = win_mask;
            sel_d      = pick_idx;
            hold_cnt_d = HOLD_W'(1);
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Unused mux inputs and select bits are tied low for N < 8.
  always_comb begin
    mux_d            = '0;
    mux_d[N-1:0]     = in;
    mux_sel          = '0;
    mux_sel[SEL_W-1:0] = sel_q;
  end

  mux8to1 u_mux (
    .d   (mux_d),
    .sel (mux_sel),
    .y   (mux_y)
  );

  // y samples the mux with the current (registered) sel/busy, so it lags
  // the grant by one cycle.
  always_comb begin
    y_d = (state_q == GRANT) ? mux_y : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      sel_q      <= '0;
      y_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      y_q        <= y_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = (state_q == GRANT);
  assign y    = y_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (N=8, MAX_HOLD=4).
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       y;
`ifdef RR_MUX_ARBITER_LOCK_EN
  logic       lock;
`endif

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .in    (in),
`ifdef RR_MUX_ARBITER_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .y     (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check the structural invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("inv_gnt_sel", 32'(gnt[sel]), 32'(busy));
  endtask

  task automatic chk_grant(input string tag, input logic [7:0] eg, input logic [2:0] es,
                           input logic eb);
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_sel"}, 32'(sel), 32'(es));
    chk({tag, "_busy"}, 32'(busy), 32'(eb));
  endtask

  initial begin
    logic [7:0] exp_g;
    rst_n = 1'b0;
    req   = 8'hFF;
    in    = 8'h00;
`ifdef RR_MUX_ARBITER_LOCK_EN
    lock  = 1'b0;
`endif
    // Reset held two cycles with all requests up.
    tick();
    tick();
    chk_grant("reset", 8'h00, 3'd0, 1'b0);
    chk("reset_y", 32'(y), 32'd0);

    // Release: first edge grants requester 0, then strict 4-cycle rotation.
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'h01 << (k % 8);
      for (int c = 0; c < 4; c++) begin
        chk_grant("rotate", exp_g, 3'(k % 8), 1'b1);
        tick();
      end
    end
    chk_grant("rotate_next", 8'h02, 3'd1, 1'b1);

    // All requests gone: back to IDLE, sel holds 1, ptr now 2.
    req = 8'h00;
    tick();
    chk_grant("idle1", 8'h00, 3'd1, 1'b0);

    // Drop release: 2 and 5 request, 2 wins from ptr=2.
    req = 8'h24;
    tick();
    chk_grant("drop_g2a", 8'h04, 3'd2, 1'b1);
    tick();
    chk_grant("drop_g2b", 8'h04, 3'd2, 1'b1);
    req = 8'h20;
    tick();
    chk_grant("drop_g5", 8'h20, 3'd5, 1'b1);
    req = 8'h00;
    tick();
    chk_grant("drop_idle", 8'h00, 3'd5, 1'b0);

    // Sole requester 3 (found by wrapping from ptr=6), kept indefinitely.
    req = 8'h08;
    tick();
    chk_grant("sole_start", 8'h08, 3'd3, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("sole_hold_gnt", 32'(gnt), 32'h08);
    end
    // Competitor 1 arrives with the count saturated: switch next edge.
    req = 8'h0A;
    tick();
    chk_grant("sole_switch", 8'h02, 3'd1, 1'b1);

    // Data path: grant requester 6 from IDLE.
    req = 8'h00;
    tick();
    chk("data_idle_busy", 32'(busy), 32'd0);
    req = 8'h40;
    tick();
    chk_grant("data_g6", 8'h40, 3'd6, 1'b1);
    chk("data_y0", 32'(y), 32'd0);
    in = 8'h48;
    tick();
    chk("data_y1", 32'(y), 32'd1);
    in = 8'h08;
    tick();
    chk("data_y2", 32'(y), 32'd0);
    in = 8'h40;
    tick();
    chk("data_y3", 32'(y), 32'd1);
    in = 8'h08;
    tick();
    chk("data_in3_only", 32'(y), 32'd0);
    in = 8'h40;
    tick();
    chk("data_y4", 32'(y), 32'd1);

    // Mid-grant reset aborts the tenure at that edge.
    rst_n = 1'b0;
    tick();
    chk_grant("midrst", 8'h00, 3'd0, 1'b0);
    chk("midrst_y", 32'(y), 32'd0);
    rst_n = 1'b1;
    req   = 8'h00;
    tick();
    chk("postrst_y", 32'(y), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);

`ifdef RR_MUX_ARBITER_LOCK_EN
    // Lock keeps requester 0 past the hold limit; releasing lock hands to 1.
    req  = 8'h03;
    lock = 1'b1;
    tick();
    chk_grant("lock_g0", 8'h01, 3'd0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("lock_hold", 32'(gnt), 32'h01);
    end
    lock = 1'b0;
    tick();
    chk_grant("lock_rel", 8'h02, 3'd1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
